// File: rtl/lcd_framebuffer_writer.sv
// lcd_framebuffer_writer: packs the PPU 2-bit pixel stream four-per-byte into framebuffer write requests.
// Define DOUBLE_BUFFER_EN to alternate write banks per frame; otherwise a single bank-0 framebuffer is used.
module lcd_framebuffer_writer #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 144
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        lcd_en_in,
   input  logic [1:0]  pixel_in,
   input  logic        pixel_valid_in,
   input  logic        hblank_in,
   input  logic        vblank_in,
   input  logic        err_clear_in,
   output logic [13:0] wr_addr_out,
   output logic [7:0]  wr_data_out,
   output logic        wr_en_out,
   output logic        frame_done_out,
   output logic [7:0]  frame_count_out,
   output logic        line_err_out,
   output logic        display_bank_out
);
   localparam int XW  = $clog2(SCREEN_W + 1);
   localparam int YW  = $clog2(SCREEN_H + 1);
   localparam int BPL = SCREEN_W / 4;

   logic [XW-1:0] x_q, x_d, x_a;
   logic [YW-1:0] y_q, y_d;
   logic [1:0]    slot_q, slot_d, slot_a;
   logic [7:0]    pack_q, pack_d, pack_a;
   logic          hb_q, vb_q, hb_edge, vb_edge;
   logic          wr_en_q, wr_en_d, wr_bank_q, wr_bank_d;
   logic [12:0]   wr_off_q, wr_off_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          fd_q, fd_d, err_q, err_d, bank_q, bank_d, disp_q, disp_d;
   logic [7:0]    fc_q, fc_d;
   logic          accept, drop, line_end, short_line;

   always_comb begin
      hb_edge    = hblank_in & ~hb_q;
      vb_edge    = vblank_in & ~vb_q;
      accept     = pixel_valid_in & lcd_en_in & (x_q < XW'(SCREEN_W)) & (y_q < YW'(SCREEN_H));
      drop       = pixel_valid_in & lcd_en_in & ~accept;
      pack_a     = pack_q;
      if (accept) pack_a[{~slot_q, 1'b0} +: 2] = pixel_in;
      // x_a/slot_a are the position after this cycle's pixel, so a same-cycle line end sees it
      x_a        = accept ? x_q + 1'b1 : x_q;
      slot_a     = accept ? slot_q + 2'd1 : slot_q;
      line_end   = lcd_en_in & (hb_edge | vb_edge);
      short_line = line_end & (x_a != '0) & (x_a < XW'(SCREEN_W));
      wr_en_d    = (accept & (slot_a == 2'd0)) | (line_end & (slot_a != 2'd0));
      wr_off_d   = wr_en_d ? 13'(y_q) * 13'(BPL) + 13'((x_a - 1'b1) >> 2) : wr_off_q;
      wr_data_d  = wr_en_d ? pack_a : wr_data_q;
      wr_bank_d  = wr_en_d ? bank_q : wr_bank_q;
      x_d        = (~lcd_en_in | line_end) ? '0 : x_a;
      slot_d     = (~lcd_en_in | line_end) ? '0 : slot_a;
      pack_d     = (~lcd_en_in | line_end | wr_en_d) ? '0 : pack_a;
      fd_d       = lcd_en_in & vb_edge;
      y_d        = (~lcd_en_in | fd_d) ? '0 :
                   (line_end & hb_edge & (x_a != '0) & (y_q != YW'(SCREEN_H))) ? y_q + 1'b1 : y_q;
      fc_d       = fc_q + 8'(fd_d);
      err_d      = (drop | short_line) ? 1'b1 : err_clear_in ? 1'b0 : err_q;
`ifdef DOUBLE_BUFFER_EN
      bank_d     = bank_q ^ fd_d;
      disp_d     = fd_d ? bank_q : disp_q;
`else
      bank_d     = 1'b0;
      disp_d     = 1'b0;
`endif
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         x_q       <= '0;
         y_q       <= '0;
         slot_q    <= '0;
         pack_q    <= '0;
         hb_q      <= 1'b0;
         vb_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_off_q  <= '0;
         wr_data_q <= '0;
         wr_bank_q <= 1'b0;
         fd_q      <= 1'b0;
         fc_q      <= '0;
         err_q     <= 1'b0;
         bank_q    <= 1'b0;
         disp_q    <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         slot_q    <= slot_d;
         pack_q    <= pack_d;
         hb_q      <= hblank_in;
         vb_q      <= vblank_in;
         wr_en_q   <= wr_en_d;
         wr_off_q  <= wr_off_d;
         wr_data_q <= wr_data_d;
         wr_bank_q <= wr_bank_d;
         fd_q      <= fd_d;
         fc_q      <= fc_d;
         err_q     <= err_d;
         bank_q    <= bank_d;
         disp_q    <= disp_d;
      end
   end

   assign wr_addr_out      = {wr_bank_q, wr_off_q};
   assign wr_data_out      = wr_data_q;
   assign wr_en_out        = wr_en_q;
   assign frame_done_out   = fd_q;
   assign frame_count_out  = fc_q;
   assign line_err_out     = err_q;
   assign display_bank_out = disp_q;
endmodule

// File: tb/tb_lcd_framebuffer_writer.sv
// tb_lcd_framebuffer_writer: randomized pixel stream checked by a write/frame scoreboard against a line-buffer model.
module tb_lcd_framebuffer_writer;
   localparam int W = 160;
   localparam int H = 144;
`ifdef DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic        clk_in = 0, rst_in = 1, lcd_en_in = 0, pixel_valid_in = 0;
   logic        hblank_in = 0, vblank_in = 0, err_clear_in = 0;
   logic [1:0]  pixel_in = 0;
   logic [13:0] wr_addr_out;
   logic [7:0]  wr_data_out, frame_count_out;
   logic        wr_en_out, frame_done_out, line_err_out, display_bank_out;

   lcd_framebuffer_writer dut (
      .clk_in(clk_in), .rst_in(rst_in), .lcd_en_in(lcd_en_in), .pixel_in(pixel_in),
      .pixel_valid_in(pixel_valid_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
      .err_clear_in(err_clear_in), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
      .wr_en_out(wr_en_out), .frame_done_out(frame_done_out), .frame_count_out(frame_count_out),
      .line_err_out(line_err_out), .display_bank_out(display_bank_out)
   );

   always #5 clk_in = ~clk_in;

   int tests = 0, fails = 0;
   logic [13:0] qa[$];
   logic [7:0]  qd[$];
   int          qf[$];
   int          mx, my, mfc;
   bit          merr, mbank, mdisp, mhbp, mvbp;
   int          line_px[W];

   task automatic chk(string n, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] packb(int b);
      logic [7:0] d = 0;
      for (int k = 0; k < 4; k++) d = {d[5:0], (b*4+k < mx) ? 2'(line_px[b*4+k]) : 2'b00};
      return d;
   endfunction

   task automatic push_wr(int b);
      qa.push_back({mbank, 13'(my*(W/4) + b)});
      qd.push_back(packb(b));
   endtask

   task automatic model(logic v, logic [1:0] p, logic hb, logic vb, logic clr);
      bit set = 0;
      bit hbe = hb & ~mhbp;
      bit vbe = vb & ~mvbp;
      if (lcd_en_in) begin
         if (v) begin
            if (mx < W && my < H) begin
               line_px[mx] = p;
               mx++;
               if (mx % 4 == 0) push_wr(mx/4 - 1);
            end else set = 1;
         end
         if (hbe || vbe) begin
            if (mx % 4 != 0) push_wr(mx/4);
            if (mx > 0 && mx < W) set = 1;
            if (vbe) begin
               mx = 0; my = 0;
               mfc = (mfc + 1) % 256;
               qf.push_back(mfc);
               mdisp = DB ? mbank : 1'b0;
               mbank = DB ? ~mbank : 1'b0;
            end else if (mx > 0) begin
               mx = 0;
               if (my < H) my++;
            end
         end
      end else begin
         mx = 0; my = 0;
      end
      if (set) merr = 1;
      else if (clr) merr = 0;
      mhbp = hb; mvbp = vb;
   endtask

   task automatic cyc(logic v, logic [1:0] p, logic hb, logic vb, logic clr);
      pixel_valid_in = v; pixel_in = p; hblank_in = hb; vblank_in = vb; err_clear_in = clr;
      model(v, p, hb, vb, clr);
      @(posedge clk_in);
      @(negedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 0;
      pixel_valid_in = 0; hblank_in = 0; vblank_in = 0; err_clear_in = 0;
      mx = 0; my = 0; mfc = 0; merr = 0; mbank = 0; mdisp = 0; mhbp = 0; mvbp = 0;
      qa.delete(); qd.delete(); qf.delete();
      #1;
      chk("rst wr_en", wr_en_out, 0);
      chk("rst wr_addr", wr_addr_out, 0);
      chk("rst wr_data", wr_data_out, 0);
      chk("rst frame_done", frame_done_out, 0);
      chk("rst frame_count", frame_count_out, 0);
      chk("rst line_err", line_err_out, 0);
      chk("rst display_bank", display_bank_out, 0);
      @(posedge clk_in);
      @(negedge clk_in);
      #1;
      rst_in = 1;
   endtask

   task automatic line(int n, bit hbl);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) cyc(0, 0, 0, 0, 0);
         cyc(1, 2'($urandom), hbl && i == n-1, 0, 0);
      end
      if (!hbl) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, $urandom_range(0, 15) == 0);
   endtask

   logic [13:0] ea;
   logic [7:0]  ed;
   always @(negedge clk_in) begin
      if (rst_in) begin
         if (wr_en_out) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected write: addr %0h data %0h, none required", wr_addr_out, wr_data_out);
            end else begin
               ea = qa.pop_front();
               ed = qd.pop_front();
               chk("wr_addr", wr_addr_out, ea);
               chk("wr_data", wr_data_out, ed);
            end
         end
         if (frame_done_out) begin
            if (qf.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected frame_done: count %0d, none required", frame_count_out);
            end else chk("frame_done count", frame_count_out, qf.pop_front());
         end
         chk("line_err", line_err_out, merr);
         chk("frame_count", frame_count_out, mfc);
         chk("display_bank", display_bank_out, mdisp);
      end
   end

   initial begin
      lcd_en_in = 1;
      #2 do_reset();
      repeat (6) cyc(1, 2'($urandom), 0, 0, 0);
      do_reset();
      cyc(1, 3, 0, 0, 0); cyc(1, 2, 0, 0, 0); cyc(1, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
      repeat (10) cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      while (my < H) begin
         line((my == 7) ? W + 1 : W, $urandom_range(0, 3) == 0);
         if (my % 16 == 3) begin
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0);
         end
      end
      line(8, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      line(W, 0);
      repeat (6) cyc(1, 2'($urandom), 0, 0, 0);
      cyc(1, 2'($urandom), 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      lcd_en_in = 0;
      repeat (5) cyc(1, 2'($urandom), 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      lcd_en_in = 1;
      repeat (3) cyc(1, 2'($urandom), 0, 0, 0);
      lcd_en_in = 0;
      cyc(0, 0, 0, 0, 0);
      lcd_en_in = 1;
      repeat (4) cyc(1, 2'($urandom), 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      chk("pending writes", qa.size(), 0);
      chk("pending frames", qf.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lcd_framebuffer_writer.md
Name: lcd_framebuffer_writer

Overview:
Downstream consumer of the pixel processing unit's pixel stream. Accepts 2-bit shade pixels with a valid strobe and tracks screen position from pixel count and hblank/vblank edges. Packs four pixels per byte and issues BRAM write requests into a 160x144 framebuffer that the display/HDMI side reads. Reports frame completion and sticky stream-integrity errors.

Parameters:
SCREEN_W, 160, pixels per line; must be a multiple of 4.
SCREEN_H, 144, lines per frame.

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  asynchronous, active-low reset
lcd_en_in  input  1  LCD enable (LCDC bit 7); low holds block idle
pixel_in  input  2  shade index from PPU
pixel_valid_in  input  1  single-cycle pixel strobe
hblank_in  input  1  PPU hblank level
vblank_in  input  1  PPU vblank level
err_clear_in  input  1  clears line_err_out
wr_addr_out  output  14  framebuffer byte address; bit 13 = bank
wr_data_out  output  8  packed pixels; first pixel of the byte in [7:6]
wr_en_out  output  1  single-cycle write strobe
frame_done_out  output  1  single-cycle pulse at frame end
frame_count_out  output  8  completed frames, wraps 255->0
line_err_out  output  1  sticky stream error
display_bank_out  output  1  bank the display side should read

Behaviour:
- Reset (rst_in low, async): all outputs 0; x=0, y=0, pack register=0, slot=0, write bank=0, hblank/vblank edge registers=0.
- Edge detect: registered previous hblank/vblank; edge = level & ~prev.
- Pixel accept (pixel_valid_in & lcd_en_in & x<SCREEN_W & y<SCREEN_H): shift the pixel into the pack register at slot (slot0->[7:6] ... slot3->[1:0]); slot++; x++.
- On the 4th accepted pixel: the next cycle drives wr_en_out=1, wr_data_out=packed byte, wr_addr_out={bank, y*(SCREEN_W/4) + (x-1)/4}. Latency is 1 cycle; outputs are registered. slot returns to 0.
- Pixel when x==SCREEN_W or y>=SCREEN_H: dropped, line_err_out set.
- hblank rising edge: if 0<x<SCREEN_W, flush the partial byte zero-padded (one write next cycle) and set line_err_out. Then x=0, slot=0, y++ (saturates at SCREEN_H). If x==0, no write; y is unchanged, so a double edge does not skip a row.
- Same-cycle pixel_valid_in and hblank edge: the pixel is accepted into the current line first, then the line end is processed. If that completes a byte, only one write occurs.
- vblank rising edge: flush any partial byte as for hblank. x=0, y=0, slot=0. frame_done_out pulses the next cycle; frame_count_out++.
- lcd_en_in low: x, y, slot and the pack register clear. No writes, frame_done_out=0, and the pending partial byte is discarded. Counters and line_err_out hold.
- err_clear_in clears line_err_out. A same-cycle set wins.
- wr_en_out and frame_done_out are never high for more than one consecutive cycle per event.

Optional Feature:
DOUBLE_BUFFER_EN.
- Defined: the write bank toggles on every vblank rising edge, in the same cycle as frame_done_out. wr_addr_out[13] = write bank; display_bank_out = ~write bank, so the display reads the last completed frame.
- Undefined: wr_addr_out[13] and display_bank_out are tied to 0 (single framebuffer, 5760 bytes).

Test Plan:
- Reset mid-line: after 6 pixels, assert rst_in low. All outputs go to 0 immediately. 4 subsequent pixels (lcd_en_in=1) -> write at addr 0.
- Pixels 3,2,1,0 on line 0 -> one cycle later wr_en_out=1, wr_data_out=8'hE4, wr_addr_out=0.
- Full line of 160 pixels with y=5, then hblank edge -> 40 writes at addrs 200..239; no error; y becomes 6.
- Short line (10 pixels of 1) then hblank edge -> writes 8'h55, 8'h55, 8'h50 at line base; line_err_out=1. err_clear_in clears it.
- 144 full lines then vblank edge -> frame_done_out pulses once; frame_count_out=1. With DOUBLE_BUFFER_EN, the next frame's first write is at addr 14'h2000 and display_bank_out=0.
- 161st pixel before hblank -> dropped, no extra write, line_err_out=1. Pixel with lcd_en_in=0 -> no write.
